// File: rtl/phase_sequencer_if.sv
// phase_sequencer_if: run/fetch/decode inputs and phase strobe outputs of the sequencer
interface phase_sequencer_if #(
  parameter int OPS_W = 4,
  parameter int CNT_W = 32
);
  logic             run;
  logic             halt_req;
  logic             mem_ready;
  logic [OPS_W-1:0] num_of_ope;
  logic             fetch_strobe;
  logic             decode_strobe;
  logic             select_strobe;
  logic             exec_strobe;
  logic [1:0]       op_index;
  logic             eip_strobe;
  logic [CNT_W-1:0] instr_count;
  logic             halted;
  logic             bad_op;
  modport master (
    output run, halt_req, mem_ready, num_of_ope,
    input  fetch_strobe, decode_strobe, select_strobe, exec_strobe, op_index,
           eip_strobe, instr_count, halted, bad_op
  );
  modport slave (
    input  run, halt_req, mem_ready, num_of_ope,
    output fetch_strobe, decode_strobe, select_strobe, exec_strobe, op_index,
           eip_strobe, instr_count, halted, bad_op
  );
endinterface

// File: rtl/phase_sequencer.sv
// phase_sequencer: variable-length one-hot phase strobe sequencer with halt/error stops
module phase_sequencer #(
  parameter int MAX_OPS = 3,
  parameter int OPS_W   = 4,
  parameter int CNT_W   = 32
) (
  input logic               clk,
  input logic               reset,
  phase_sequencer_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, SELECT, EXEC, EIPUPD, HALT, ERR} state_e;
  state_e           state_q, state_d;
  logic [OPS_W-1:0] n_q, n_d;
  logic [1:0]       k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hp_q, hp_d;
  logic             bad_q, bad_d;
  logic             n_bad;
  logic             more;
  assign n_bad = bus.num_of_ope == '0 || bus.num_of_ope > OPS_W'(MAX_OPS);
  assign more  = OPS_W'(k_q) < n_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      hp_q    <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      hp_q    <= hp_d;
      bad_q   <= bad_d;
    end
  end
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    bad_d   = bad_q;
    hp_d    = hp_q | (bus.halt_req && state_q != HALT && state_q != ERR);
    unique case (state_q)
      IDLE:   state_d = bus.run ? FETCH : IDLE;
      FETCH:  state_d = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        n_d     = bus.num_of_ope;
        k_d     = 2'd1;
        bad_d   = bad_q | n_bad;
        state_d = n_bad ? ERR : SELECT;
      end
      SELECT: state_d = EXEC;
      EXEC: begin
        k_d     = more ? k_q + 2'd1 : k_q;
        state_d = more ? SELECT : EIPUPD;
      end
      EIPUPD: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = (hp_q || bus.halt_req) ? HALT : bus.run ? FETCH : IDLE;
      end
      default: state_d = state_q;
    endcase
  end
  assign bus.fetch_strobe  = state_q == FETCH;
  assign bus.decode_strobe = state_q == DECODE;
  assign bus.select_strobe = state_q == SELECT;
  assign bus.exec_strobe   = state_q == EXEC;
  assign bus.eip_strobe    = state_q == EIPUPD;
  assign bus.op_index      = (state_q == SELECT || state_q == EXEC) ? k_q : 2'd0;
  assign bus.halted        = state_q == HALT || state_q == ERR;
  assign bus.bad_op        = bad_q;
  assign bus.instr_count   = cnt_q;
endmodule
